// File: rtl/led_status_pkg.sv
// Shared constants for the status-LED controller: mode codes and field widths.
package led_status_pkg;

    localparam int unsigned LED_MODE_W = 3;
    localparam int unsigned LED_ADDR_W = 3;

    localparam logic [LED_MODE_W-1:0] LED_MODE_OFF        = LED_MODE_W'(0);
    localparam logic [LED_MODE_W-1:0] LED_MODE_ON         = LED_MODE_W'(1);
    localparam logic [LED_MODE_W-1:0] LED_MODE_BREATH     = LED_MODE_W'(2);
    localparam logic [LED_MODE_W-1:0] LED_MODE_BLINK_SLOW = LED_MODE_W'(3);
    localparam logic [LED_MODE_W-1:0] LED_MODE_BLINK_FAST = LED_MODE_W'(4);
    localparam logic [LED_MODE_W-1:0] LED_MODE_EVENT      = LED_MODE_W'(5);

endpackage

// File: rtl/led_pulse_stretch.sv
// One event stretch counter: a trigger (re)loads PULSE_CYC, then counts down to zero.
module led_pulse_stretch
    import led_status_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 5000000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_trig,
    output logic o_active
);

    localparam int unsigned CNT_W = $clog2(PULSE_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload wins over decrement so a retrigger restarts a full flash.
    always_comb begin
        cnt_d = cnt_q;
        if (i_trig) begin
            cnt_d = CNT_W'(PULSE_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_active = (cnt_q != '0);

endmodule

// File: rtl/led_status_ctrl.sv
// Per-channel status-LED controller: mode registers, shared blink prescaler, registered
// active-low drive. EVENT mode and stretch counters exist only with LED_STATUS_EVT_EN.
module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int unsigned N_LED     = 4,
    parameter int unsigned BLINK_DIV = 24,
    parameter int unsigned PULSE_CYC = 5000000
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_breath,
    input  logic                  i_wr_en,
    input  logic [LED_ADDR_W-1:0] i_wr_addr,
    input  logic [LED_MODE_W-1:0] i_wr_data,
    input  logic [N_LED-1:0]      i_evt,
    output logic [N_LED-1:0]      o_led_n
);

    logic [N_LED-1:0][LED_MODE_W-1:0] mode_q;
    logic [N_LED-1:0][LED_MODE_W-1:0] mode_d;
    logic [BLINK_DIV-1:0]             blink_q;
    logic [BLINK_DIV-1:0]             blink_d;
    logic [N_LED-1:0]                 led_n_q;
    logic [N_LED-1:0]                 led_n_d;

`ifdef LED_STATUS_EVT_EN
    logic [N_LED-1:0] evt_active;

    for (genvar g = 0; g < N_LED; g++) begin : g_stretch
        led_pulse_stretch #(
            .PULSE_CYC (PULSE_CYC)
        ) u_stretch (
            .i_clk    (i_clk),
            .i_rstn   (i_rstn),
            .i_trig   (i_evt[g]),
            .o_active (evt_active[g])
        );
    end
`else
    logic unused_evt;
    assign unused_evt = ^i_evt;
`endif

    always_comb begin
        mode_d  = mode_q;
        blink_d = blink_q + BLINK_DIV'(1);
        led_n_d = '1;

        // Out-of-range addresses match no channel and are dropped.
        for (int i = 0; i < N_LED; i++) begin
            if (i_wr_en && (i_wr_addr == LED_ADDR_W'(i))) begin
                mode_d[i] = i_wr_data;
            end
        end

        for (int i = 0; i < N_LED; i++) begin
            case (mode_q[i])
                LED_MODE_OFF:        led_n_d[i] = 1'b1;
                LED_MODE_ON:         led_n_d[i] = 1'b0;
                LED_MODE_BREATH:     led_n_d[i] = i_breath;
                LED_MODE_BLINK_SLOW: led_n_d[i] = ~blink_q[BLINK_DIV-1];
                LED_MODE_BLINK_FAST: led_n_d[i] = ~blink_q[BLINK_DIV-3];
`ifdef LED_STATUS_EVT_EN
                LED_MODE_EVENT:      led_n_d[i] = ~evt_active[i];
`endif
                default:             led_n_d[i] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mode_q  <= '0;
            blink_q <= '0;
            led_n_q <= '1;
        end else begin
            mode_q  <= mode_d;
            blink_q <= blink_d;
            led_n_q <= led_n_d;
        end
    end

    assign o_led_n = led_n_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: mode-write vector table, per-cycle scoreboard against a
// behavioural model, and directed blink/event/breath/reset sequences.
module tb_led_status_ctrl;

    localparam int unsigned N_LED     = 4;
    localparam int unsigned BLINK_DIV = 6;
    localparam int unsigned PULSE_CYC = 10;
`ifdef LED_STATUS_EVT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       breath;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] wr_data;
    logic [3:0] evt;
    logic [3:0] led_n;

    led_status_ctrl #(
        .N_LED     (N_LED),
        .BLINK_DIV (BLINK_DIV),
        .PULSE_CYC (PULSE_CYC)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_breath  (breath),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_evt     (evt),
        .o_led_n   (led_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] m_mode [4];
    logic [5:0] m_blink;
    int         m_cnt  [4];
    logic [3:0] exp_q [$];

    typedef struct {
        logic [2:0] addr;
        logic [2:0] data;
        logic       breath;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl [10];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 3'd0;
            m_cnt[i]  = 0;
        end
        m_blink = 6'd0;
        exp_q.delete();
    endtask

    // One clock: predict the next output, clock, advance the model, compare.
    task automatic step();
        logic [3:0] e;
        logic [3:0] got;
        for (int i = 0; i < 4; i++) begin
            case (m_mode[i])
                3'd1:    e[i] = 1'b0;
                3'd2:    e[i] = breath;
                3'd3:    e[i] = ~m_blink[5];
                3'd4:    e[i] = ~m_blink[3];
                3'd5:    e[i] = EVT_EN ? (m_cnt[i] == 0) : 1'b1;
                default: e[i] = 1'b1;
            endcase
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (wr_en && (wr_addr < 3'd4)) m_mode[wr_addr] = wr_data;
        m_blink = m_blink + 6'd1;
        for (int i = 0; i < 4; i++) begin
            if (evt[i]) m_cnt[i] = PULSE_CYC;
            else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end
        #1;
        got = led_n;
        check4("scoreboard", got, exp_q.pop_front());
    endtask

    task automatic do_write(input logic [2:0] a, input logic [2:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        int   last0;
        int   last1;
        logic prev0;
        logic prev1;

        tbl[0] = '{3'd2, 3'd1, 1'b1, 4'b1011};
        tbl[1] = '{3'd5, 3'd1, 1'b1, 4'b1011};
        tbl[2] = '{3'd0, 3'd2, 1'b0, 4'b1010};
        tbl[3] = '{3'd0, 3'd2, 1'b1, 4'b1011};
        tbl[4] = '{3'd1, 3'd1, 1'b1, 4'b1001};
        tbl[5] = '{3'd1, 3'd7, 1'b1, 4'b1011};
        tbl[6] = '{3'd2, 3'd6, 1'b1, 4'b1111};
        tbl[7] = '{3'd3, 3'd1, 1'b1, 4'b0111};
        tbl[8] = '{3'd7, 3'd0, 1'b1, 4'b0111};
        tbl[9] = '{3'd3, 3'd0, 1'b1, 4'b1111};

        rstn = 1'b0; breath = 1'b1; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; evt = '0;
        model_reset();
        #12;
        check4("reset_value", led_n, 4'b1111);
        #10 rstn = 1'b1;

        // Mode-write vectors: write at edge k, visible at edge k+1.
        for (int v = 0; v < 10; v++) begin
            breath = tbl[v].breath;
            do_write(tbl[v].addr, tbl[v].data);
            step();
            check4("wr_table", led_n, tbl[v].exp);
        end

        // Reset mid-run with channel 0 ON.
        do_write(3'd0, 3'd1);
        step();
        check1("on_before_reset", led_n[0], 1'b0);
        #3 rstn = 1'b0;
        #1 check4("async_reset", led_n, 4'b1111);
        model_reset();
        #2 rstn = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check4("after_reset", led_n, 4'b1111);

        // Blink: slow on ch0, fast on ch1; rewrite slow mid-period.
        do_write(3'd0, 3'd3);
        do_write(3'd1, 3'd4);
        prev0 = led_n[0]; prev1 = led_n[1];
        last0 = -1; last1 = -1;
        for (int c = 0; c < 140; c++) begin
            if (c == 50) do_write(3'd0, 3'd3);
            else step();
            if (led_n[0] != prev0) begin
                if (last0 >= 0) check4("slow_period", 4'(c - last0), 4'(32));
                last0 = c;
                prev0 = led_n[0];
            end
            if (led_n[1] != prev1) begin
                if (last1 >= 0) check4("fast_period", 4'(c - last1), 4'(8));
                last1 = c;
                prev1 = led_n[1];
            end
        end
        check1("slow_toggled", last0 >= 0, 1'b1);
        do_write(3'd0, 3'd0);
        do_write(3'd1, 3'd0);

        // Single event on ch3.
        do_write(3'd3, 3'd5);
        step();
        evt[3] = 1'b1;
        step();
        evt[3] = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            check1("evt_single", led_n[3], (EVT_EN && j <= 10) ? 1'b0 : 1'b1);
        end

        // Retrigger at k+6 extends to k+16.
        evt[3] = 1'b1;
        step();
        evt[3] = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            if (j == 6) evt[3] = 1'b1;
            step();
            evt[3] = 1'b0;
            check1("evt_retrig", led_n[3], (EVT_EN && j <= 16) ? 1'b0 : 1'b1);
        end

        // Write and event to the same channel in the same cycle.
        evt[2] = 1'b1;
        do_write(3'd2, 3'd5);
        evt[2] = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            step();
            check1("evt_with_write", led_n[2], (EVT_EN && j <= 10) ? 1'b0 : 1'b1);
        end

        // Breath pass-through on ch1, then reserved mode 7.
        do_write(3'd1, 3'd2);
        for (int c = 0; c < 40; c++) begin
            breath = 1'($urandom_range(0, 1));
            step();
            check1("breath_pass", led_n[1], breath);
        end
        do_write(3'd1, 3'd7);
        for (int c = 0; c < 20; c++) begin
            breath = 1'($urandom_range(0, 1));
            evt = 4'($urandom_range(0, 15));
            step();
            check1("mode7_off", led_n[1], 1'b1);
        end
        evt = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
